// File: rtl/cia_tod.sv
// CIA time-of-day clock: 50/60 Hz prescaler, BCD tenths..hours chain, read latch and alarm.
// Optional build macro CIA_TOD_PM_FLIP_EN enables the 6526 PM flip on hours=12 time writes.

module bcd_add #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] d,
  input  logic [W-1:0] lim,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         co
);
  // Wraps to zero with carry only at the exact limit; anything else just counts up.
  always_comb begin
    q  = d;
    co = 1'b0;
    if (inc) begin
      if (d == lim) begin
        q  = '0;
        co = 1'b1;
      end else begin
        q = d + W'(1);
      end
    end
  end
endmodule

module cia_tod (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tod_tick,
  input  logic       todin_50,
  input  logic       alarm_sel,
  input  logic       we,
  input  logic       re,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       alarm_irq
);

  localparam int unsigned PRE_W = 3;

  typedef struct packed {
    logic       pm;
    logic [4:0] hr;
    logic [6:0] mn;
    logic [6:0] sc;
    logic [3:0] tn;
  } tod_t;

  tod_t             tod_q, tod_d, alm_q, alm_d, lat_q, lat_d, tod_inc, src;
  logic [PRE_W-1:0] pre_q, pre_d, pre_lim;
  logic             run_q, run_d, latched_q, latched_d, irq_d;
  logic             tenth_pulse, time_we, alm_we;
  logic [3:0]       tn_inc, sl_inc, ml_inc, hl_inc;
  logic [2:0]       sh_inc, mh_inc;
  logic             tn_co, sl_co, sh_co, ml_co, mh_co, hl_co;

  always_comb begin
    pre_lim     = todin_50 ? PRE_W'(4) : PRE_W'(5);
    tenth_pulse = run_q && tod_tick && (pre_q == pre_lim);
    time_we     = we && !alarm_sel;
    alm_we      = we && alarm_sel;
  end

  bcd_add #(.W(4)) u_tn (.d(tod_q.tn),      .lim(4'd9), .inc(tenth_pulse), .q(tn_inc), .co(tn_co));
  bcd_add #(.W(4)) u_sl (.d(tod_q.sc[3:0]), .lim(4'd9), .inc(tn_co),       .q(sl_inc), .co(sl_co));
  bcd_add #(.W(3)) u_sh (.d(tod_q.sc[6:4]), .lim(3'd5), .inc(sl_co),       .q(sh_inc), .co(sh_co));
  bcd_add #(.W(4)) u_ml (.d(tod_q.mn[3:0]), .lim(4'd9), .inc(sh_co),       .q(ml_inc), .co(ml_co));
  bcd_add #(.W(3)) u_mh (.d(tod_q.mn[6:4]), .lim(3'd5), .inc(ml_co),       .q(mh_inc), .co(mh_co));
  bcd_add #(.W(4)) u_hl (.d(tod_q.hr[3:0]), .lim(4'd9), .inc(mh_co),       .q(hl_inc), .co(hl_co));

  // Hours run 12 -> 01 .. 11 -> 12, with PM flipping on the way into 12.
  always_comb begin
    tod_inc    = tod_q;
    tod_inc.tn = tn_inc;
    tod_inc.sc = {sh_inc, sl_inc};
    tod_inc.mn = {mh_inc, ml_inc};
    if (mh_co) begin
      if (tod_q.hr == 5'h12) tod_inc.hr = 5'h01;
      else                   tod_inc.hr = {tod_q.hr[4] ^ hl_co, hl_inc};
      if (tod_q.hr == 5'h11) tod_inc.pm = ~tod_q.pm;
    end
  end

  always_comb begin
    tod_d     = tod_q;
    alm_d     = alm_q;
    lat_d     = lat_q;
    pre_d     = pre_q;
    run_d     = run_q;
    latched_d = latched_q;

    if (run_q && tod_tick) pre_d = (pre_q >= pre_lim) ? '0 : pre_q + PRE_W'(1);

    // A time write wins over the increment due in the same cycle.
    if (time_we) begin
      case (addr)
        2'd0: begin
          tod_d.tn = wdata[3:0];
          run_d    = 1'b1;
        end
        2'd1: tod_d.sc = wdata[6:0];
        2'd2: tod_d.mn = wdata[6:0];
        default: begin
          tod_d.hr = wdata[4:0];
`ifdef CIA_TOD_PM_FLIP_EN
          tod_d.pm = (wdata[4:0] == 5'h12) ? ~wdata[7] : wdata[7];
`else
          tod_d.pm = wdata[7];
`endif
          run_d    = 1'b0;
          pre_d    = '0;
        end
      endcase
    end else if (tenth_pulse) begin
      tod_d = tod_inc;
    end

    if (alm_we) begin
      case (addr)
        2'd0:    alm_d.tn = wdata[3:0];
        2'd1:    alm_d.sc = wdata[6:0];
        2'd2:    alm_d.mn = wdata[6:0];
        default: begin
          alm_d.hr = wdata[4:0];
          alm_d.pm = wdata[7];
        end
      endcase
    end

    if (re && (addr == 2'd3) && !latched_q) begin
      lat_d     = tod_q;
      latched_d = 1'b1;
    end else if (re && (addr == 2'd0)) begin
      latched_d = 1'b0;
    end

    irq_d = (tod_d == alm_d) && (tod_q != alm_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tod_q     <= '{pm: 1'b0, hr: 5'h01, mn: 7'h00, sc: 7'h00, tn: 4'h0};
      alm_q     <= '0;
      lat_q     <= '0;
      pre_q     <= '0;
      run_q     <= 1'b1;
      latched_q <= 1'b0;
      alarm_irq <= 1'b0;
    end else begin
      tod_q     <= tod_d;
      alm_q     <= alm_d;
      lat_q     <= lat_d;
      pre_q     <= pre_d;
      run_q     <= run_d;
      latched_q <= latched_d;
      alarm_irq <= irq_d;
    end
  end

  // Read mux: frozen snapshot while latched, live time otherwise.
  always_comb begin
    src   = latched_q ? lat_q : tod_q;
    rdata = '0;
    case (addr)
      2'd0:    rdata = {4'b0, src.tn};
      2'd1:    rdata = {1'b0, src.sc};
      2'd2:    rdata = {1'b0, src.mn};
      default: rdata = {src.pm, 2'b0, src.hr};
    endcase
  end

endmodule
